bubblesort_result_compactor: RTL and testbench
==============================================

# bubblesort_result_compactor

Response-side companion to the random stimulus generators in the out-of-core bubblesort wrapper. The block samples the sorter's `readdata_o` bus each time `done_o` rises and folds it, one slice per cycle, into a multiple-input signature register (MISR). The resulting signature and a result counter are the only observable outputs, so the sorter's result path survives synthesis and can be checked against a golden value.

## Interface
Parameters:
- `DATA_W`, 392: width of the sorter result bus; must be a multiple of `SLICE_W`.
- `SLICE_W`, 56: MISR width and fold slice width; `NSLICE = DATA_W/SLICE_W` (7 by default).
- `POLY`, 56'h80_0000_0000_0095: feedback taps, XORed in when the MISR MSB shifts out.
- `SEED`, 0: MISR value after reset or clear.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset; asynchronous, active-low.
- `readdata_i`  in  DATA_W: sorter result bus.
- `done_i`  in  1: sorter done level.
- `clear_i`  in  1: synchronous clear of signature, count and flags.
- `signature_o`  out  SLICE_W: MISR register, driven directly.
- `sig_valid_o`  out  1: one-cycle pulse when a fold completes.
- `count_o`  out  16: number of completed folds; saturates at 16'hFFFF.
- `busy_o`  out  1: high in FOLD.
- `overrun_o`  out  1: sticky; a `done_i` rising edge was dropped.

## Operation
- `done_q` registers `done_i`. A rising edge is `done_i & ~done_q`; a held-high `done_i` counts as one edge.
- States:
  - IDLE to FOLD on a rising edge. That edge loads `shadow <= readdata_i` and sets `idx <= 0`.
  - FOLD folds one slice per clock, `misr <= {misr[SLICE_W-2:0],1'b0} ^ (misr[SLICE_W-1] ? POLY : 0) ^ shadow[idx*SLICE_W +: SLICE_W]`, then increments `idx`.
  - When `idx == NSLICE-1`, FOLD returns to IDLE: `count_o` increments (saturating) and `sig_valid_o` is 1 in the following cycle.
- Slice 0 (bits `[SLICE_W-1:0]`) is folded first.
- A rising edge in FOLD is dropped and sets `overrun_o`; the shadow register is not overwritten.
- A rising edge on the cycle FOLD returns to IDLE is also dropped and sets `overrun_o`.
- `clear_i` has priority over everything. It sets `misr <= SEED`, `count_o <= 0`, `overrun_o <= 0` and `state <= IDLE`, aborts any fold without pulsing `sig_valid_o`, and captures no edge that cycle. `done_q` still updates.
- Reset values: `signature_o=SEED`, `sig_valid_o=0`, `count_o=0`, `busy_o=0`, `overrun_o=0`, state IDLE, `done_q=0`, `idx=0`, `shadow=0`.
- Reset asserted mid-fold forces all of the above immediately; deassertion returns to IDLE.

## Timing
- E0 is the capture edge. Folds occur at edges E1..E(NSLICE); the last fold at E7 updates `signature_o`.
- `busy_o` is high from E0 to E(NSLICE). `sig_valid_o` is high between E(NSLICE) and E(NSLICE+1).
- Minimum spacing between accepted captures is NSLICE+1 cycles.
- `readdata_i` need only be stable in the cycle `done_i` rises.

## Structure
- Package `compactor_pkg` holds:
  - the state enum `cmp_state_t {IDLE, FOLD}`;
  - `DEFAULT_POLY`;
  - the function `misr_next(misr, slice, poly)`.
- Sub-module `misr_slice_sel` is the combinational `NSLICE`:1 slice mux, selected by `idx`. The FSM, counter and MISR stay in the top.

## Test plan
- Seed 0, `readdata_i=0`, one `done_i` pulse -> `signature_o=0`, `count_o=1`, `sig_valid_o` pulses at E7.
- Seed 0, `readdata_i=1`, one pulse -> `signature_o=56'h40`.
- Seed 0, `readdata_i=1<<336`, one pulse -> `signature_o=56'h1`.
- `done_i` held high for 20 cycles -> `count_o=1`, `overrun_o=0`.
- Second `done_i` rising edge at E3 -> `overrun_o=1` and `count_o=1` after completion. Then `clear_i` -> `overrun_o=0`, `count_o=0`, `signature_o=SEED`.
- `clear_i` at E4 -> no `sig_valid_o` pulse, `signature_o=SEED`, `busy_o=0` next cycle.
- `rst` driven low at E4 (asynchronous, mid-fold) -> all outputs at reset values immediately.
- Release `rst`, then one pulse with `readdata_i=1` -> `signature_o=56'h40`.

Source files
------------

// File: rtl/bubblesort_result_compactor_pkg.sv
// Shared types and MISR step function for the bubblesort result compactor.
// MISR words are carried at a fixed maximum width and masked to the live width.
package compactor_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FOLD = 1'b1
  } cmp_state_t;

  localparam logic [55:0] DEFAULT_POLY = 56'h80_0000_0000_0095;

  localparam int MISR_MAX_W = 64;
  localparam int MISR_IDX_W = 6;

  typedef logic [MISR_MAX_W-1:0] misr_word_t;

  // One MISR step at width w: shift left, XOR taps when the MSB leaves, XOR in the slice.
  function automatic misr_word_t misr_next(input misr_word_t misr,
                                           input misr_word_t slice,
                                           input misr_word_t poly,
                                           input int         w);
    misr_word_t mask;
    mask = {MISR_MAX_W{1'b1}} >> (MISR_MAX_W - w);
    return ((misr << 1) & mask) ^ (misr[MISR_IDX_W'(w - 1)] ? poly : '0) ^ slice;
  endfunction

endpackage

// File: rtl/bubblesort_result_compactor_misr_slice_sel.sv
// Combinational NSLICE:1 mux picking the result slice folded this cycle.
module misr_slice_sel
  import compactor_pkg::*;
#(
  parameter int DATA_W  = 392,
  parameter int SLICE_W = 56,
  parameter int NSLICE  = DATA_W / SLICE_W,
  parameter int IDX_W   = 3
) (
  input  logic [DATA_W-1:0]  data,
  input  logic [IDX_W-1:0]   idx,
  output logic [SLICE_W-1:0] slice
);

  always_comb begin
    slice = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx == IDX_W'(i)) slice = data[i*SLICE_W +: SLICE_W];
    end
  end

endmodule

// File: rtl/bubblesort_result_compactor.sv
// Captures the sorter result on each done rising edge and folds it, one slice
// per clock, into a MISR; exposes signature, fold count and overrun flag.
module bubblesort_result_compactor
  import compactor_pkg::*;
#(
  parameter int                 DATA_W  = 392,
  parameter int                 SLICE_W = 56,
  parameter logic [SLICE_W-1:0] POLY    = DEFAULT_POLY,
  parameter logic [SLICE_W-1:0] SEED    = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  readdata_i,
  input  logic               done_i,
  input  logic               clear_i,
  output logic [SLICE_W-1:0] signature_o,
  output logic               sig_valid_o,
  output logic [15:0]        count_o,
  output logic               busy_o,
  output logic               overrun_o
);

  localparam int NSLICE = DATA_W / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  cmp_state_t         state;
  logic               done_q;
  logic               rise;
  logic [IDX_W-1:0]   idx;
  logic [DATA_W-1:0]  shadow;
  logic [SLICE_W-1:0] misr;
  logic [SLICE_W-1:0] slice;
  logic [SLICE_W-1:0] misr_nxt;

  function automatic logic [15:0] count_sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign rise        = done_i & ~done_q;
  assign signature_o = misr;

  misr_slice_sel #(
    .DATA_W  (DATA_W),
    .SLICE_W (SLICE_W),
    .NSLICE  (NSLICE),
    .IDX_W   (IDX_W)
  ) u_slice_sel (
    .data  (shadow),
    .idx   (idx),
    .slice (slice)
  );

  assign misr_nxt = SLICE_W'(misr_next(misr_word_t'(misr), misr_word_t'(slice),
                                       misr_word_t'(POLY), SLICE_W));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      done_q      <= 1'b0;
      idx         <= '0;
      shadow      <= '0;
      misr        <= SEED;
      sig_valid_o <= 1'b0;
      count_o     <= '0;
      busy_o      <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      done_q      <= done_i;
      sig_valid_o <= 1'b0;
      if (clear_i) begin
        // Clear aborts any fold and ignores an edge arriving this cycle.
        state     <= IDLE;
        misr      <= SEED;
        count_o   <= '0;
        overrun_o <= 1'b0;
        busy_o    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              shadow <= readdata_i;
              idx    <= '0;
              state  <= FOLD;
              busy_o <= 1'b1;
            end
          end
          FOLD: begin
            misr <= misr_nxt;
            if (rise) overrun_o <= 1'b1;
            if (idx == IDX_W'(NSLICE - 1)) begin
              state       <= IDLE;
              busy_o      <= 1'b0;
              idx         <= '0;
              count_o     <= count_sat_inc(count_o);
              sig_valid_o <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bubblesort_result_compactor.sv
// Directed bench for bubblesort_result_compactor with a scoreboard monitor on sig_valid_o.
module tb_bubblesort_result_compactor;

  localparam int DATA_W  = 392;
  localparam int SLICE_W = 56;

  logic               clk = 1'b0;
  logic               rst;
  logic [DATA_W-1:0]  readdata_i;
  logic               done_i;
  logic               clear_i;
  logic [SLICE_W-1:0] signature_o;
  logic               sig_valid_o;
  logic [15:0]        count_o;
  logic               busy_o;
  logic               overrun_o;

  typedef struct packed {
    logic [55:0] sig;
    logic [15:0] cnt;
    logic        ovr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bubblesort_result_compactor #(
    .DATA_W  (DATA_W),
    .SLICE_W (SLICE_W),
    .POLY    (56'h80_0000_0000_0095),
    .SEED    (56'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .readdata_i  (readdata_i),
    .done_i      (done_i),
    .clear_i     (clear_i),
    .signature_o (signature_o),
    .sig_valid_o (sig_valid_o),
    .count_o     (count_o),
    .busy_o      (busy_o),
    .overrun_o   (overrun_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: every completed fold must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && sig_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got sig_valid_o=1 with signature %h, required no pulse", signature_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_signature", 64'(signature_o), 64'(mon_e.sig));
        chk("sb_count", 64'(count_o), 64'(mon_e.cnt));
        chk("sb_overrun", 64'(overrun_o), 64'(mon_e.ovr));
      end
    end
  end

  // Drives one capture edge (E0); on return time is the negedge after E0.
  task automatic fire(input logic [DATA_W-1:0] d, input bit push,
                      input logic [55:0] es, input logic [15:0] ec, input logic eo);
    exp_t e;
    readdata_i = d;
    done_i     = 1'b1;
    if (push) begin
      e.sig = es;
      e.cnt = ec;
      e.ovr = eo;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    done_i     = 1'b0;
    readdata_i = '1;
    @(negedge clk);
    chk("busy_after_e0", 64'(busy_o), 64'd1);
  endtask

  task automatic finish_fold();
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("valid_at_e7", 64'(sig_valid_o), 64'd1);
    chk("busy_low_e7", 64'(busy_o), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("valid_low_e8", 64'(sig_valid_o), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    @(posedge clk);
    #1;
    clear_i = 1'b0;
    @(negedge clk);
    chk("clr_signature", 64'(signature_o), 64'd0);
    chk("clr_count", 64'(count_o), 64'd0);
    chk("clr_overrun", 64'(overrun_o), 64'd0);
    @(posedge clk);
    #1;
  endtask

  logic [DATA_W-1:0] v;
  int seen;

  initial begin
    rst        = 1'b0;
    done_i     = 1'b0;
    clear_i    = 1'b0;
    readdata_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_signature", 64'(signature_o), 64'd0);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_overrun", 64'(overrun_o), 64'd0);
    chk("rst_valid", 64'(sig_valid_o), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Zero data, then a single low bit (count accumulates to 2).
    fire('0, 1'b1, 56'h0, 16'd1, 1'b0);
    finish_fold();
    v = DATA_W'(1);
    fire(v, 1'b1, 56'h40, 16'd2, 1'b0);
    finish_fold();

    // Bit in the last slice is folded last.
    do_clear();
    v = DATA_W'(1) << 336;
    fire(v, 1'b1, 56'h1, 16'd1, 1'b0);
    finish_fold();

    // MSB of slice 0 exercises the feedback taps on every later step.
    do_clear();
    v = DATA_W'(1) << 55;
    fire(v, 1'b1, 56'h80_0000_0000_1CB3, 16'd1, 1'b0);
    finish_fold();

    // done_i held high counts as one edge.
    do_clear();
    readdata_i = DATA_W'(1);
    done_i     = 1'b1;
    exp_q.push_back('{sig: 56'h40, cnt: 16'd1, ovr: 1'b0});
    repeat (20) @(posedge clk);
    #1;
    done_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("held_count", 64'(count_o), 64'd1);
    chk("held_overrun", 64'(overrun_o), 64'd0);
    @(posedge clk);
    #1;

    // Second rising edge at E3 is dropped and flagged; shadow is kept.
    do_clear();
    v = DATA_W'(1);
    fire(v, 1'b1, 56'h40, 16'd1, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    done_i = 1'b1;
    @(posedge clk);
    #1;
    done_i = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("ovr_valid_e7", 64'(sig_valid_o), 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("ovr_sticky", 64'(overrun_o), 64'd1);
    chk("ovr_count", 64'(count_o), 64'd1);
    @(posedge clk);
    #1;
    do_clear();

    // Clear at E4 aborts the fold with no pulse.
    fire(v, 1'b0, 56'h0, 16'd0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    clear_i = 1'b1;
    @(posedge clk);
    #1;
    clear_i = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy_o), 64'd0);
    chk("abort_signature", 64'(signature_o), 64'd0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (sig_valid_o === 1'b1) seen++;
    end
    chk("abort_no_valid", 64'(seen), 64'd0);
    @(posedge clk);
    #1;

    // Completed fold, then asynchronous reset mid-fold at E4.
    fire(v, 1'b1, 56'h40, 16'd1, 1'b0);
    finish_fold();
    fire(v, 1'b0, 56'h0, 16'd0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_signature", 64'(signature_o), 64'd0);
    chk("arst_count", 64'(count_o), 64'd0);
    chk("arst_busy", 64'(busy_o), 64'd0);
    chk("arst_overrun", 64'(overrun_o), 64'd0);
    chk("arst_valid", 64'(sig_valid_o), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    fire(v, 1'b1, 56'h40, 16'd1, 1'b0);
    finish_fold();

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
